load_store_unit: RTL and testbench
==================================

# load_store_unit

Pipeline-side initiator for the word-organised data memory. Accepts RV32 load/store requests from the MEM stage and translates byte/halfword accesses into word transactions on the data memory port. Sub-word stores use a two-cycle read-modify-write sequence. Loads are sign- or zero-extended. `busy` stalls the pipeline while a multi-cycle access is in flight.

## Interface
- `MEM_BITS`, default 12: word-address width of the data memory (4096 words).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present this cycle.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32 funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `busy` out 1: unit not in IDLE; upstream holds its request.
- `rsp_valid` out 1: one-cycle pulse, load data valid.
- `rsp_rdata` out 32: extended load result.
- `misaligned_err` out 1: one-cycle pulse, request rejected.
- `dm_addr` out MEM_BITS: word address, equal to `req_addr[MEM_BITS+1:2]`.
- `dm_din` out 32: write data to memory.
- `dm_we` out 1: memory write enable.
- `dm_dout` in 32: memory read data, registered, valid one cycle after the address.

## Operation
- States: IDLE, LOAD_WAIT, RMW.
- A request is accepted only in IDLE with `req_valid`=1. In any other state `req_valid` is ignored.
- **LW/LH/LHU/LB/LBU:** in IDLE, drive `dm_addr` with `dm_we`=0 and go to LOAD_WAIT.
  - In LOAD_WAIT, select the lane from the latched `addr[1:0]`.
  - Sign-extend for LB/LH; zero-extend for LBU/LHU.
  - Register the result into `rsp_rdata`, pulse `rsp_valid`, and return to IDLE.
- **SW:** in IDLE, `dm_we`=1 and `dm_din`=`req_wdata`. Stays in IDLE, never asserts `busy`, produces no response.
- **SB/SH:** in IDLE, read the word (`dm_we`=0) and go to RMW.
  - In RMW, `dm_din` = `dm_dout` with the target byte/half replaced by latched `wdata[7:0]`/`[15:0]`.
  - `dm_we`=1 on the same `dm_addr`; return to IDLE.
- Address, funct3 and wdata are latched on acceptance. Upstream changes after acceptance have no effect.
- Illegal funct3 (load 011/110/111, store 011–111): request dropped. No memory access, no response, no error.
- Address bits above `MEM_BITS+1` are ignored, so accesses wrap modulo memory size.
- `rst`=1 forces state to IDLE and `dm_we`=0 in that same cycle, so an RMW is aborted with no partial write.
- Reset values:
  - `busy`, `rsp_valid`, `misaligned_err`, `dm_we`: 0
  - `rsp_rdata`: 0
  - `dm_addr`, `dm_din`: 0

## Timing
- Load accepted in cycle N:
  - `busy`=1 in N+1.
  - `rsp_valid`=1 in N+2, at which point the unit is IDLE and can accept a new request.
- Sub-word store accepted in N: write occurs in N+1 (`busy`=1 in N+1); unit is IDLE in N+2.
- SW: write in N, zero stall.
- `busy` is combinational from state. `misaligned_err` and `rsp_valid` are registered pulses.
- The combinational path `dm_dout` → merge → `dm_din` is confined to the RMW state.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - Word access with `addr[1:0]`≠0, or half access with `addr[0]`=1, is rejected.
  - No memory access occurs; `misaligned_err` pulses in N+1; no `rsp_valid`.
- Undefined: offending low bits are cleared (access aligned down) and the access proceeds normally. `misaligned_err` is tied 0.

## Structure
- Shared package `lsu_pkg`:
  - funct3 constants (LB=000, LH=001, LW=010, LBU=100, LHU=101, SB=000, SH=001, SW=010).
  - state encoding.
- One combinational sub-module `lsu_lane_mux`: load extraction/extension plus store merge, driven by offset and funct3.

## Test plan
- Reset mid-RMW: SB accepted, `rst`=1 in N+1 → `dm_we` stays 0; memory word unchanged.
- SW at 0x10 with 0xDEADBEEF, then LW at 0x10 → `dm_we` in N at `dm_addr`=4; `rsp_rdata`=0xDEADBEEF at N+2.
- Word 0x80FF7F01 at `dm_addr` 1. Back-to-back loads, each issued the cycle `busy` drops:
  - LB 0x4 → 0x00000001
  - LB 0x7 → 0xFFFFFF80
  - LBU 0x7 → 0x00000080
  - LH 0x6 → 0xFFFF80FF
  - LHU 0x6 → 0x000080FF
- SB 0xAA at 0x5 onto 0x11223344 → written word 0x1122AA44, `busy` high exactly one cycle.
- SH 0xBEEF at 0x6 onto 0x11223344 → 0xBEEF3344.
- LW at 0x3:
  - With the macro: `misaligned_err` pulse, no `rsp_valid`, no `dm_we`.
  - Without: returns the word at 0x0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared funct3 codes, FSM encoding and request legality for the load/store unit.
// Pure declarations: no latency, no backpressure.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD_WAIT = 2'd1,
    ST_RMW       = 2'd2
  } lsu_state_t;

  function automatic logic is_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

endpackage

// File: rtl/lsu_lane_mux.sv
// Byte/half lane extraction with sign/zero extension, and sub-word store merge.
// Purely combinational: zero latency, no backpressure.
module lsu_lane_mux
  import lsu_pkg::*;
(
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_word,
  input  logic [15:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_off)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
    w_half = i_off[1] ? i_word[31:16] : i_word[15:0];

    case (i_funct3)
      F3_LB:   o_load = {{24{w_byte[7]}}, w_byte};
      F3_LH:   o_load = {{16{w_half[15]}}, w_half};
      F3_LBU:  o_load = {24'h0, w_byte};
      F3_LHU:  o_load = {16'h0, w_half};
      default: o_load = i_word;
    endcase

    o_merged = i_word;
    if (i_funct3[1:0] == 2'b00)
      o_merged[{i_off, 3'b000} +: 8] = i_wdata[7:0];
    else if (i_funct3[1:0] == 2'b01)
      o_merged[{i_off[1], 4'b0000} +: 16] = i_wdata[15:0];
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32 load/store to word memory; sub-word stores by read-modify-write. LSU_MISALIGN_TRAP_EN rejects misaligned accesses.
// Loads respond 2 cycles after acceptance, SB/SH write 1 cycle after, SW writes at once; busy holds upstream off.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_BITS = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic                req_we,
  input  logic [2:0]          req_funct3,
  input  logic [31:0]         req_addr,
  input  logic [31:0]         req_wdata,
  output logic                busy,
  output logic                rsp_valid,
  output logic [31:0]         rsp_rdata,
  output logic                misaligned_err,
  output logic [MEM_BITS-1:0] dm_addr,
  output logic [31:0]         dm_din,
  output logic                dm_we,
  input  logic [31:0]         dm_dout
);

  lsu_state_t          r_state;
  logic [MEM_BITS-1:0] r_addr;
  logic [1:0]          r_off;
  logic [2:0]          r_f3;
  logic [15:0]         r_wdata;
  logic                r_rsp_valid;
  logic [31:0]         r_rsp_rdata;
  logic                r_err;

  logic                w_legal;
  logic                w_misaligned;
  logic [1:0]          w_off;
  logic [31:0]         w_load;
  logic [31:0]         w_merged;
  logic                w_unused_addr;

  assign w_legal       = req_valid && is_legal(req_we, req_funct3);
  assign w_unused_addr = &{1'b0, req_addr[31:MEM_BITS+2]};

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_misaligned = ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)) ||
                        ((req_funct3[1:0] == 2'b01) && req_addr[0]);
`else
  assign w_misaligned = 1'b0;
`endif

  // Offset aligned down to the access size; only matters when trapping is off.
  always_comb begin
    case (req_funct3[1:0])
      2'b10:   w_off = 2'b00;
      2'b01:   w_off = {req_addr[1], 1'b0};
      default: w_off = req_addr[1:0];
    endcase
  end

  lsu_lane_mux u_lane_mux (
    .i_off    (r_off),
    .i_funct3 (r_f3),
    .i_word   (dm_dout),
    .i_wdata  (r_wdata),
    .o_load   (w_load),
    .o_merged (w_merged)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_off       <= '0;
      r_f3        <= '0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_err       <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_err       <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_legal) begin
            if (w_misaligned) begin
              r_err <= 1'b1;
            end else if (!req_we || (req_funct3 != F3_SW)) begin
              r_addr  <= req_addr[MEM_BITS+1:2];
              r_off   <= w_off;
              r_f3    <= req_funct3;
              r_wdata <= req_wdata[15:0];
              r_state <= req_we ? ST_RMW : ST_LOAD_WAIT;
            end
          end
        end
        ST_LOAD_WAIT: begin
          r_rsp_valid <= 1'b1;
          r_rsp_rdata <= w_load;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Memory port is combinational so SW and the RMW write need no extra cycle;
  // reset gates it so an in-flight RMW never lands a partial write.
  always_comb begin
    dm_addr = '0;
    dm_din  = '0;
    dm_we   = 1'b0;
    if (!rst) begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            dm_addr = req_addr[MEM_BITS+1:2];
            dm_din  = req_wdata;
          end
          dm_we = w_legal && req_we && (req_funct3 == F3_SW) && !w_misaligned;
        end
        ST_LOAD_WAIT: dm_addr = r_addr;
        ST_RMW: begin
          dm_addr = r_addr;
          dm_din  = w_merged;
          dm_we   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy           = (r_state != ST_IDLE);
  assign rsp_valid      = r_rsp_valid;
  assign rsp_rdata      = r_rsp_rdata;
  assign misaligned_err = r_err;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: behavioural memory, per-cycle expectation tables built from the
// access timing rules, one compare process, plus literal checks on key results.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        busy, rsp_valid, misaligned_err, dm_we;
  logic [31:0] rsp_rdata, dm_din, dm_dout;
  logic [11:0] dm_addr;

  load_store_unit #(.MEM_BITS(12)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .busy(busy), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .misaligned_err(misaligned_err), .dm_addr(dm_addr), .dm_din(dm_din),
    .dm_we(dm_we), .dm_dout(dm_dout)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:4095];
  logic [31:0] model_mem [0:4095];
  always @(posedge clk) begin
    if (dm_we) mem[dm_addr] <= dm_din;
    dm_dout <= mem[dm_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit        e_busy [0:1023];
  bit        e_rv   [0:1023];
  bit        e_we   [0:1023];
  bit        e_err  [0:1023];
  bit        e_achk [0:1023];
  bit [31:0] e_rdata[0:1023];
  bit [11:0] e_addr [0:1023];
  bit [31:0] e_din  [0:1023];

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      int c;
      c = cyc;
      chk("dm_we", {31'h0, dm_we}, {31'h0, rst ? 1'b0 : e_we[c]});
      if (!rst) begin
        chk("busy", {31'h0, busy}, {31'h0, e_busy[c]});
        chk("rsp_valid", {31'h0, rsp_valid}, {31'h0, e_rv[c]});
        chk("misaligned_err", {31'h0, misaligned_err}, {31'h0, e_err[c]});
        if (e_rv[c]) chk("rsp_rdata", rsp_rdata, e_rdata[c]);
        if (e_we[c] || e_achk[c]) chk("dm_addr", {20'h0, dm_addr}, {20'h0, e_addr[c]});
        if (e_we[c]) chk("dm_din", dm_din, e_din[c]);
      end
    end
  end

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [2:0] f3, input int off);
    logic [31:0] v;
    v = w >> (8 * off);
    case (f3)
      3'b000: begin v = v & 32'hFF;   if (v >= 32'h80)   v = v | 32'hFFFFFF00; end
      3'b001: begin v = v & 32'hFFFF; if (v >= 32'h8000) v = v | 32'hFFFF0000; end
      3'b100: v = v & 32'hFF;
      3'b101: v = v & 32'hFFFF;
      default: v = w;
    endcase
    return v;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input int wa, input logic [31:0] val);
    mem[wa] = val;
    model_mem[wa] = val;
  endtask

  // The cycle after acceptance: either reset or a stray request that must be ignored.
  task automatic busy_cycle(input bit abort);
    next_cycle();
    if (abort) begin
      rst = 1'b1; req_valid = 1'b0;
    end else begin
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
      req_addr = 32'h3F0; req_wdata = 32'hBAD0BAD0;
    end
    next_cycle();
    rst = 1'b0;
    req_valid = 1'b0;
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input bit abort);
    int c, sz, lo, off, wa;
    bit legal, trap;
    logic [31:0] mask, nw;
    c = cyc;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    wa = int'(addr[13:2]);
    sz = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    lo = int'(addr[1:0]);
    off = lo - (lo % sz);
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
`ifdef LSU_MISALIGN_TRAP_EN
    trap = (lo % sz) != 0;
`else
    trap = 1'b0;
`endif
    if (!legal) begin
      next_cycle(); req_valid = 1'b0; return;
    end
    if (trap) begin
      e_err[c+1] = 1'b1;
      next_cycle(); req_valid = 1'b0; return;
    end
    if (!we) begin
      e_achk[c] = 1'b1; e_addr[c] = wa[11:0];
      e_busy[c+1] = 1'b1;
      e_rv[c+2] = 1'b1; e_rdata[c+2] = model_load(model_mem[wa], f3, off);
      busy_cycle(1'b0);
    end else if (sz == 4) begin
      e_we[c] = 1'b1; e_addr[c] = wa[11:0]; e_din[c] = wd;
      model_mem[wa] = wd;
      next_cycle(); req_valid = 1'b0;
    end else begin
      e_achk[c] = 1'b1; e_addr[c] = wa[11:0];
      e_busy[c+1] = 1'b1;
      if (!abort) begin
        mask = ((sz == 1) ? 32'hFF : 32'hFFFF) << (8 * off);
        nw = (model_mem[wa] & ~mask) | ((wd << (8 * off)) & mask);
        e_we[c+1] = 1'b1; e_addr[c+1] = wa[11:0]; e_din[c+1] = nw;
        model_mem[wa] = nw;
      end
      busy_cycle(abort);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i] = 32'h0;
      model_mem[i] = 32'h0;
    end
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    next_cycle();
    next_cycle();
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_err", {31'h0, misaligned_err}, 32'h0);
    chk("rst_dm_we", {31'h0, dm_we}, 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_dm_addr", {20'h0, dm_addr}, 32'h0);
    chk("rst_dm_din", dm_din, 32'h0);
    rst = 1'b0;
    chk_en = 1'b1;
    next_cycle();

    // SW then LW at 0x10
    issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0);
    chk("sw_mem", mem[4], 32'hDEADBEEF);
    issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
    chk("lw_0x10", rsp_rdata, 32'hDEADBEEF);

    // Back-to-back sub-word loads
    preload(1, 32'h80FF7F01);
    issue(1'b0, 3'b000, 32'h4, 32'h0, 1'b0); chk("lb_4",   rsp_rdata, 32'h00000001);
    issue(1'b0, 3'b000, 32'h7, 32'h0, 1'b0); chk("lb_7",   rsp_rdata, 32'hFFFFFF80);
    issue(1'b0, 3'b100, 32'h7, 32'h0, 1'b0); chk("lbu_7",  rsp_rdata, 32'h00000080);
    issue(1'b0, 3'b001, 32'h6, 32'h0, 1'b0); chk("lh_6",   rsp_rdata, 32'hFFFF80FF);
    issue(1'b0, 3'b101, 32'h6, 32'h0, 1'b0); chk("lhu_6",  rsp_rdata, 32'h000080FF);
    issue(1'b0, 3'b001, 32'h4, 32'h0, 1'b0); chk("lh_4",   rsp_rdata, 32'h00007F01);
    next_cycle();

    // Sub-word stores
    preload(1, 32'h11223344);
    issue(1'b1, 3'b000, 32'h5, 32'hFFFFFFAA, 1'b0);
    chk("sb_5", mem[1], 32'h1122AA44);
    preload(1, 32'h11223344);
    issue(1'b1, 3'b001, 32'h6, 32'h0000BEEF, 1'b0);
    chk("sh_6", mem[1], 32'hBEEF3344);

    // Illegal funct3 is dropped
    issue(1'b0, 3'b011, 32'h10, 32'h0, 1'b0);
    issue(1'b1, 3'b101, 32'h10, 32'h0, 1'b0);
    issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
    chk("illegal_noop", rsp_rdata, 32'hDEADBEEF);

    // Address wraps modulo memory size
    issue(1'b0, 3'b010, 32'h4010, 32'h0, 1'b0);
    chk("wrap_lw", rsp_rdata, 32'hDEADBEEF);

    // Reset in the RMW write cycle
    preload(2, 32'h55667788);
    issue(1'b1, 3'b000, 32'h8, 32'h99, 1'b1);
    next_cycle();
    chk("rmw_abort_mem", mem[2], 32'h55667788);

    // Misaligned word/half loads
    preload(0, 32'hCAFEF00D);
    issue(1'b0, 3'b010, 32'h3, 32'h0, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("lw_3_err", {31'h0, misaligned_err}, 32'h1);
`else
    chk("lw_3", rsp_rdata, 32'hCAFEF00D);
`endif
    issue(1'b0, 3'b101, 32'h7, 32'h0, 1'b0);
`ifndef LSU_MISALIGN_TRAP_EN
    chk("lhu_7", rsp_rdata, 32'h0000BEEF);
`endif
    next_cycle();
    next_cycle();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
